// File: rtl/i2s_rx.sv
// I2S slave receiver. BCLK, WS and SD are treated as asynchronous to clk and
// oversampled. The receiver deserializes them into left/right PCM words.
// It uses the standard one-bit delay: the bit sampled on the rise where WS
// changes is the LSB of the word that belongs to the previous WS value.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   i2s_bclk_in       bit clock; only its rising edges are used
//   i2s_ws_in         word select (0 = left, 1 = right)
//   i2s_d_in          serial data, MSB first
//   left_data_out     last complete left word, held until the next pair
//   right_data_out    last complete right word, held until the next pair
//   sample_valid_out  one-clk pulse when a new L/R pair is presented
//   short_err_out     one-clk pulse when a word had fewer than SAMPLE_W bits
//   locked_out        high once frame alignment has been acquired
//   err_count_out     saturating count of short words
//                     (only present when I2S_RX_ERR_CNT_EN is defined)
module i2s_rx #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned CNT_W    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i2s_bclk_in,
  input  logic                i2s_ws_in,
  input  logic                i2s_d_in,
  output logic [SAMPLE_W-1:0] left_data_out,
  output logic [SAMPLE_W-1:0] right_data_out,
  output logic                sample_valid_out,
  output logic                short_err_out,
  output logic                locked_out
`ifdef I2S_RX_ERR_CNT_EN
  ,
  output logic [7:0]          err_count_out
`endif
);

  localparam logic [SAMPLE_W-1:0] MSB_ONE   = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]    CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]    SHORT_LIM = CNT_W'(SAMPLE_W - 1);

  typedef enum logic {SYNC, RUN} state_t;

  logic [2:0]          bclk_sync;
  logic [1:0]          ws_sync;
  logic [1:0]          d_sync;
  logic                rise_c;

  logic                rise_q;
  logic                ws_q;
  logic                d_q;

  logic [SAMPLE_W-1:0] shreg;
  logic [SAMPLE_W-1:0] word_c;
  logic [CNT_W-1:0]    bit_cnt;
  logic                ws_prev;

  logic                done_v;
  logic                done_right;
  logic                done_short;
  logic [SAMPLE_W-1:0] done_word;

  state_t              state;
  logic                have_left;
  logic [SAMPLE_W-1:0] left_hold;

  // Two-flop synchronizers; the third BCLK flop feeds the rise detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync <= '0;
      ws_sync   <= '0;
      d_sync    <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], i2s_bclk_in};
      ws_sync   <= {ws_sync[0], i2s_ws_in};
      d_sync    <= {d_sync[0], i2s_d_in};
    end
  end

  assign rise_c = bclk_sync[1] & ~bclk_sync[2];

  // Detect stage: register the rise together with the WS/SD values it samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      ws_q   <= 1'b0;
      d_q    <= 1'b0;
    end else begin
      rise_q <= rise_c;
      ws_q   <= ws_sync[1];
      d_q    <= d_sync[1];
    end
  end

  // The word is kept left-aligned. Each bit lands at position SAMPLE_W-1-bit_cnt,
  // so short words are zero-filled and bits past SAMPLE_W are masked to nothing.
  assign word_c = d_q ? (shreg | (MSB_ONE >> bit_cnt)) : shreg;

  // Capture stage: shift bits and close a word on each WS change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      ws_prev    <= 1'b0;
      done_v     <= 1'b0;
      done_right <= 1'b0;
      done_short <= 1'b0;
      done_word  <= '0;
    end else begin
      done_v <= 1'b0;
      if (rise_q) begin
        if (ws_q != ws_prev) begin
          done_v     <= 1'b1;
          done_word  <= word_c;
          done_right <= ws_prev;
          done_short <= (bit_cnt < SHORT_LIM);
          ws_prev    <= ws_q;
          bit_cnt    <= '0;
          shreg      <= '0;
        end else begin
          shreg <= word_c;
          if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Frame FSM: acquire lock on the first boundary, then pair left with right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= SYNC;
      have_left        <= 1'b0;
      left_hold        <= '0;
      left_data_out    <= '0;
      right_data_out   <= '0;
      sample_valid_out <= 1'b0;
      short_err_out    <= 1'b0;
      locked_out       <= 1'b0;
    end else begin
      sample_valid_out <= 1'b0;
      short_err_out    <= 1'b0;
      if (done_v) begin
        case (state)
          SYNC: begin
            state      <= RUN;
            locked_out <= 1'b1;
          end
          RUN: begin
            short_err_out <= done_short;
            if (!done_right) begin
              left_hold <= done_word;
              have_left <= 1'b1;
            end else if (have_left) begin
              left_data_out    <= left_hold;
              right_data_out   <= done_word;
              sample_valid_out <= 1'b1;
              have_left        <= 1'b0;
            end
          end
        endcase
      end
    end
  end

`ifdef I2S_RX_ERR_CNT_EN
  // Saturating short-word counter; it is updated alongside the short_err_out pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_out <= '0;
    end else if (done_v && (state == RUN) && done_short && (err_count_out != 8'hFF)) begin
      err_count_out <= err_count_out + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Randomized bench for i2s_rx. It uses a word-level reference model: each
// transmitted word's received value is derived arithmetically from its slot
// length. The word sequence decides which L/R pairs must appear.
module tb_i2s_rx;

  localparam int unsigned SW   = 16;
  localparam int unsigned HALF = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bclk, ws, sd;
  logic [SW-1:0] left_data, right_data;
  logic          valid, short_err, locked;
`ifdef I2S_RX_ERR_CNT_EN
  logic [7:0]    err_count;
`endif

  i2s_rx #(.SAMPLE_W(SW), .CNT_W(6)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i2s_bclk_in      (bclk),
    .i2s_ws_in        (ws),
    .i2s_d_in         (sd),
    .left_data_out    (left_data),
    .right_data_out   (right_data),
    .sample_valid_out (valid),
    .short_err_out    (short_err),
    .locked_out       (locked)
`ifdef I2S_RX_ERR_CNT_EN
    ,
    .err_count_out    (err_count)
`endif
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [SW-1:0] exp_l_q[$];
  logic [SW-1:0] exp_r_q[$];
  bit            m_locked;
  bit            m_have_left;
  logic [SW-1:0] m_hold;
  int            exp_short = 0;
  int            exp_short_rst = 0;

  // Observed state
  logic [SW-1:0] cur_l = '0;
  logic [SW-1:0] cur_r = '0;
  int            act_short = 0;
  int            pulse_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // The value the receiver must report for an n-bit word sent MSB-first.
  function automatic logic [SW-1:0] received(input logic [31:0] val, input int n);
    logic [63:0] wide;
    if (n >= int'(SW)) wide = 64'(val) >> (n - int'(SW));
    else               wide = 64'(val) << (int'(SW) - n);
    return wide[SW-1:0];
  endfunction

  task automatic model_reset();
    m_locked      = 1'b0;
    m_have_left   = 1'b0;
    m_hold        = '0;
    exp_short_rst = 0;
  endtask

  // A word of channel ch closes: apply the lock/pairing rules.
  task automatic complete_word(input bit ch, input logic [31:0] val, input int n);
    logic [SW-1:0] w;
    w = received(val, n);
    if (!m_locked) begin
      m_locked = 1'b1;
    end else begin
      if (n < int'(SW)) begin
        exp_short++;
        exp_short_rst++;
      end
      if (!ch) begin
        m_hold      = w;
        m_have_left = 1'b1;
      end else if (m_have_left) begin
        exp_l_q.push_back(m_hold);
        exp_r_q.push_back(w);
        m_have_left = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic measure_latency();
    int k;
    k = 0;
    @(posedge clk);  // edge that registers BCLK high
    while (k < 10) begin
      @(posedge clk);
      #1;
      k++;
      if (valid) break;
    end
    check("latency_edges", 32'(k), 32'd4);
  endtask

  task automatic send_bit(input bit w, input bit d, input bit meas);
    ws = w;
    sd = d;
    repeat (HALF) tick();
    bclk = 1'b1;
    if (meas) fork measure_latency(); join_none
    repeat (HALF) tick();
    bclk = 1'b0;
  endtask

  // One word: WS flips on its last bit (the one-bit delay of I2S).
  task automatic send_word(input bit ch, input logic [31:0] val, input int n, input bit meas);
    complete_word(ch, val, n);
    for (int i = 0; i < n; i++)
      send_bit((i == n - 1) ? ~ch : ch, val[n-1-i], meas && (i == n - 1));
  endtask

  function automatic logic [31:0] rand_word(input int n);
    logic [63:0] mask;
    mask = (64'd1 << n) - 64'd1;
    return 32'(64'($urandom) & mask);
  endfunction

  task automatic check_errcnt(input string name);
`ifdef I2S_RX_ERR_CNT_EN
    check(name, 32'(err_count), 32'((exp_short_rst > 255) ? 255 : exp_short_rst));
`endif
  endtask

  // Compare process: pairs must match the model, outputs must hold otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      cur_l = '0;
      cur_r = '0;
      check("rst_left", 32'(left_data), 32'd0);
      check("rst_right", 32'(right_data), 32'd0);
      check("rst_flags", {29'd0, valid, short_err, locked}, 32'd0);
    end else begin
      if (short_err) act_short++;
      if (valid) begin
        pulse_cnt++;
        if (exp_l_q.size() == 0) begin
          check("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          cur_l = exp_l_q.pop_front();
          cur_r = exp_r_q.pop_front();
          check("pair_left", 32'(left_data), 32'(cur_l));
          check("pair_right", 32'(right_data), 32'(cur_r));
        end
      end else begin
        check("hold_left", 32'(left_data), 32'(cur_l));
        check("hold_right", 32'(right_data), 32'(cur_r));
      end
    end
  end

  initial begin
    int p0;
    int s0;
    int n;
    rst_n = 1'b0;
    bclk  = 1'b0;
    ws    = 1'b0;
    sd    = 1'b0;
    model_reset();
    repeat (5) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("locked_after_reset", 32'(locked), 32'd0);

    // Standard frames, 32-bit slots
    p0 = pulse_cnt; s0 = act_short;
    for (int f = 0; f < 4; f++) begin
      send_word(1'b0, 32'hA5C3_0000, 32, 1'b0);
      send_word(1'b1, 32'h1234_0000, 32, 1'b0);
    end
    repeat (20) tick();
    check("std_pulses", 32'(pulse_cnt - p0), 32'd3);
    check("std_left", 32'(left_data), 32'h0000_A5C3);
    check("std_right", 32'(right_data), 32'h0000_1234);
    check("std_short", 32'(act_short - s0), 32'd0);
    check("std_locked", 32'(locked), 32'd1);

    // Short 12-bit slots
    p0 = pulse_cnt; s0 = act_short;
    for (int f = 0; f < 4; f++) begin
      send_word(1'b0, 32'hABC, 12, 1'b0);
      send_word(1'b1, 32'h123, 12, 1'b0);
    end
    repeat (20) tick();
    check("short_pulses", 32'(pulse_cnt - p0), 32'd4);
    check("short_left", 32'(left_data), 32'h0000_ABC0);
    check("short_right", 32'(right_data), 32'h0000_1230);
    check("short_errs", 32'(act_short - s0), 32'd8);
`ifdef I2S_RX_ERR_CNT_EN
    check("err_count_8", 32'(err_count), 32'd8);
`endif

    // Latency measured on the R->L boundary rise
    send_word(1'b0, 32'h5A5A, 16, 1'b0);
    send_word(1'b1, 32'hC3C3, 16, 1'b1);
    repeat (20) tick();

    // Two boundaries on consecutive rises: 1-bit right word
    s0 = act_short;
    send_word(1'b0, 32'h0F0F, 16, 1'b0);
    send_word(1'b1, 32'h1, 1, 1'b0);
    send_word(1'b0, 32'h7777, 16, 1'b0);
    send_word(1'b1, 32'h8888, 16, 1'b0);
    repeat (20) tick();
    check("onebit_short", 32'(act_short - s0), 32'd1);

    // Random slot lengths and data
    for (int i = 0; i < 40; i++) begin
      n = int'($urandom_range(1, 32));
      send_word(1'(i % 2), rand_word(n), n, 1'b0);
    end
    repeat (20) tick();
    check_errcnt("err_count_rand");

    // Lock acquisition starting mid-right-word
    rst_n = 1'b0;
    repeat (4) tick();
    model_reset();
    rst_n = 1'b1;
    repeat (3) tick();
    check("relock_pre", 32'(locked), 32'd0);
    p0 = pulse_cnt;
    complete_word(1'b0, 32'h0, 1);  // first WS=1 rise closes an implicit left word
    send_word(1'b1, rand_word(10), 10, 1'b0);
    repeat (10) tick();
    check("lock_mid_right", 32'(locked), 32'd1);
    check("lock_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    send_word(1'b0, 32'h1357_0000, 32, 1'b0);
    send_word(1'b1, 32'h2468_0000, 32, 1'b0);
    repeat (20) tick();
    check("lock_pulses", 32'(pulse_cnt - p0), 32'd1);

    // Reset in the middle of a left word, then the stream continues
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'($urandom), 1'b0);
    rst_n = 1'b0;
    repeat (5) tick();
    model_reset();
    rst_n = 1'b1;
    p0 = pulse_cnt;
    send_word(1'b0, rand_word(24), 24, 1'b0);
    send_word(1'b1, 32'hDEAD_0000, 32, 1'b0);
    send_word(1'b0, 32'hBEEF_0000, 32, 1'b0);
    send_word(1'b1, 32'hCAFE_0000, 32, 1'b0);
    repeat (20) tick();
    check("rst_mid_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("rst_mid_left", 32'(left_data), 32'h0000_BEEF);
    check("rst_mid_right", 32'(right_data), 32'h0000_CAFE);

    // Saturation run: 300 short words
    for (int i = 0; i < 300; i++) send_word(1'(i % 2), rand_word(6), 6, 1'b0);
    repeat (20) tick();
    check_errcnt("err_count_sat");
`ifdef I2S_RX_ERR_CNT_EN
    check("err_count_255", 32'(err_count), 32'd255);
`endif
    send_word(1'b0, 32'h3F, 6, 1'b0);
    send_word(1'b1, 32'h15, 6, 1'b0);
    repeat (20) tick();
    check_errcnt("err_count_hold");

    // No BCLK activity: outputs must hold (compare process checks every cycle)
    repeat (40) tick();
    check("queue_empty", 32'(exp_l_q.size()), 32'd0);
    check("short_total", 32'(act_short), 32'(exp_short));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
